// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: ALU ops, flag
// indices, opcodes, mux selects and the control FSM state set.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  localparam int FLAG_ZERO = 4;
  localparam int FLAG_LTS  = 3;
  localparam int FLAG_LTU  = 2;
  localparam int FLAG_SIGN = 1;
  localparam int FLAG_OVF  = 0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXECUTE_R, S_EXECUTE_I, S_ALU_WB, S_BRANCH, S_JALR, S_JAL,
    S_LUI, S_AUIPC, S_TRAP
  } state_e;

  // Branch condition from the SUB flags; funct3 010/011 are filtered out
  // by the FSM before this result is used.
  function automatic logic branch_taken(input logic [2:0] f3, input logic [4:0] fl);
    case (f3)
      3'b000:  return fl[FLAG_ZERO];
      3'b001:  return !fl[FLAG_ZERO];
      3'b100:  return fl[FLAG_LTS];
      3'b101:  return !fl[FLAG_LTS];
      3'b110:  return fl[FLAG_LTU];
      3'b111:  return !fl[FLAG_LTU];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Shared memory port handshake between the control unit and memory.
interface multicycle_control_unit_if;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (output mem_read, output mem_write, input mem_ready);
  modport slave  (input mem_read, input mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU operation select from instruction fields and current FSM state.
module alu_decoder
  import core_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  state_e     i_state,
  output logic [3:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_state)
      S_EXECUTE_R, S_EXECUTE_I: begin
        case (i_funct3)
          // funct7[5] on addi is immediate bits, so SUB is R-type only
          3'b000: o_alu_control = (i_opcode == OP_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: o_alu_control = ALU_SLL;
          3'b010: o_alu_control = ALU_SLT;
          3'b011: o_alu_control = ALU_SLTU;
          3'b100: o_alu_control = ALU_XOR;
          3'b101: o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      S_BRANCH: o_alu_control = ALU_SUB;
      S_LUI:    o_alu_control = ALU_LUI;
      default:  o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over one shared memory port.
module multicycle_control_unit
  import core_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int STATE_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 instr,
  input  logic [4:0]                  alu_zero_flags,
  multicycle_control_unit_if.master   mem,
  output logic                        adr_src,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        reg_write,
  output logic [1:0]                  result_src,
  output logic [1:0]                  alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [2:0]                  imm_src,
  output logic [3:0]                  alu_control,
  output logic                        instr_retired,
  output logic                        illegal_instr
);

  if (XLEN != 32 || STATE_W != $bits(state_e)) begin : g_bad_param
    $error("multicycle_control_unit: only XLEN=32, STATE_W=4 supported");
  end

  state_e     r_state, w_next;
  logic       w_mem_read, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
  logic       w_reg_write, w_retired, w_illegal;
  logic [1:0] w_result_src, w_src_a, w_src_b;
  logic [2:0] w_imm_src;
  logic [3:0] w_alu_control;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_unused_ok;

  assign w_opcode    = instr[6:0];
  assign w_funct3    = instr[14:12];
  assign w_unused_ok = ^{instr[31], instr[29:15], instr[11:7],
                         alu_zero_flags[FLAG_SIGN], alu_zero_flags[FLAG_OVF]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = RES_ALUOUT;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RS2;
    w_imm_src    = IMM_I;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (mem.mem_ready) begin
          w_ir_write   = 1'b1;
          w_src_a      = SRCA_PC;
          w_src_b      = SRCB_FOUR;
          w_result_src = RES_ALU;
          w_pc_write   = 1'b1;
          w_next       = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut catches the branch (or JAL) target for later states
        w_src_a   = SRCA_OLDPC;
        w_src_b   = SRCB_IMM;
        w_imm_src = (w_opcode == OP_JAL) ? IMM_J : IMM_B;
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
          OP_R:              w_next = S_EXECUTE_R;
          OP_I:              w_next = S_EXECUTE_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        w_src_a   = SRCA_RS1;
        w_src_b   = SRCB_IMM;
        w_imm_src = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
        w_next    = (w_opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_adr_src  = 1'b1;
        if (mem.mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_result_src = RES_RDATA;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (mem.mem_ready) w_next = S_FETCH;
      end
      S_EXECUTE_R: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_RS2;
        w_next  = S_ALU_WB;
      end
      S_EXECUTE_I: begin
        w_src_a   = SRCA_RS1;
        w_src_b   = SRCB_IMM;
        w_imm_src = IMM_I;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_RS2;
        if (w_funct3[2:1] == 2'b01) begin
          w_next = S_TRAP;
        end else begin
          w_pc_write = branch_taken(w_funct3, alu_zero_flags);
          w_next     = S_FETCH;
        end
      end
      S_JALR: begin
        w_src_a   = SRCA_RS1;
        w_src_b   = SRCB_IMM;
        w_imm_src = IMM_I;
        w_next    = S_JAL;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms OldPC + 4
        w_src_a    = SRCA_OLDPC;
        w_src_b    = SRCB_FOUR;
        w_pc_write = 1'b1;
        w_imm_src  = IMM_J;
        w_next     = S_ALU_WB;
      end
      S_LUI: begin
        w_src_b   = SRCB_IMM;
        w_imm_src = IMM_U;
        w_next    = S_ALU_WB;
      end
      S_AUIPC: begin
        w_src_a   = SRCA_OLDPC;
        w_src_b   = SRCB_IMM;
        w_imm_src = IMM_U;
        w_next    = S_ALU_WB;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    w_retired = (r_state != S_FETCH) && (w_next == S_FETCH);
  end

  alu_decoder u_alu_dec (
    .i_opcode      (w_opcode),
    .i_funct3      (w_funct3),
    .i_funct7b5    (instr[30]),
    .i_state       (r_state),
    .o_alu_control (w_alu_control)
  );

  // Reset gates every output combinationally so strobes drop at once
  assign mem.mem_read  = rst_n & w_mem_read;
  assign mem.mem_write = rst_n & w_mem_write;
  assign adr_src       = rst_n & w_adr_src;
  assign ir_write      = rst_n & w_ir_write;
  assign pc_write      = rst_n & w_pc_write;
  assign reg_write     = rst_n & w_reg_write;
  assign instr_retired = rst_n & w_retired;
  assign illegal_instr = rst_n & w_illegal;
  assign result_src    = rst_n ? w_result_src  : 2'b00;
  assign alu_src_a     = rst_n ? w_src_a       : 2'b00;
  assign alu_src_b     = rst_n ? w_src_b       : 2'b00;
  assign imm_src       = rst_n ? w_imm_src     : 3'b000;
  assign alu_control   = rst_n ? w_alu_control : 4'd0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit: expected control words
// are hand-built per state and compared once per cycle.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [4:0]  flags;
  logic        adr_src, ir_write, pc_write, reg_write, retired, illegal;
  logic [1:0]  result_src, src_a, src_b;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
  logic [20:0] outs;
  int          n_vec = 0;
  int          n_err = 0;

  multicycle_control_unit_if mem_if ();

  multicycle_control_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr          (instr),
    .alu_zero_flags (flags),
    .mem            (mem_if),
    .adr_src        (adr_src),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .reg_write      (reg_write),
    .result_src     (result_src),
    .alu_src_a      (src_a),
    .alu_src_b      (src_b),
    .imm_src        (imm_src),
    .alu_control    (alu_control),
    .instr_retired  (retired),
    .illegal_instr  (illegal)
  );

  always #5 clk = ~clk;

  assign outs = {mem_if.mem_read, mem_if.mem_write, adr_src, ir_write, pc_write,
                 reg_write, result_src, src_a, src_b, imm_src, alu_control,
                 retired, illegal};

  function automatic logic [20:0] mk(input logic mr, mw, as, irw, pcw, rw,
                                     input logic [1:0] rs, sa, sb,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic ret, ill);
    return {mr, mw, as, irw, pcw, rw, rs, sa, sb, imm, alu, ret, ill};
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // check the current state's outputs, then advance one clock
  task automatic cyc(input string tag, input logic [20:0] exp);
    #1;
    chk(tag, {11'd0, outs}, {11'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk(tag, {11'd0, outs}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [20:0] V_F, V_FW, V_D, V_DJ, V_WB;

  initial begin
    V_F  = mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,3'b000,4'd3,0,0);
    V_FW = mk(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd3,0,0);
    V_D  = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,4'd3,0,0);
    V_DJ = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b011,4'd3,0,0);
    V_WB = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,4'd3,1,0);

    rst_n = 1'b0;
    instr = enc(7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    flags = 5'b00000;
    mem_if.mem_ready = 1'b1;
    #2;
    chk("reset_outputs", {11'd0, outs}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add x3,x1,x2
    cyc("add_fetch",  V_F);
    cyc("add_decode", V_D);
    cyc("add_exec",   mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'd3,0,0));
    cyc("add_wb",     V_WB);

    // beq taken / bne not taken / bltu taken
    instr = enc(7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011);
    flags = 5'b10000;
    cyc("beq_fetch",  V_F);
    cyc("beq_decode", V_D);
    cyc("beq_branch", mk(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b000,4'd4,1,0));
    instr = enc(7'd0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011);
    cyc("bne_fetch",  V_F);
    cyc("bne_decode", V_D);
    cyc("bne_branch", mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'd4,1,0));
    instr = enc(7'd0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011);
    flags = 5'b00100;
    cyc("bltu_fetch",  V_F);
    cyc("bltu_decode", V_D);
    cyc("bltu_branch", mk(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b000,4'd4,1,0));

    // lw x5,4(x1) with a three-cycle memory stall
    instr = enc(7'd0, 5'd4, 5'd1, 3'b010, 5'd5, 7'b0000011);
    cyc("lw_fetch",  V_F);
    cyc("lw_decode", V_D);
    mem_if.mem_ready = 1'b0;
    cyc("lw_adr",    mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'd3,0,0));
    for (int i = 0; i < 3; i++)
      cyc("lw_stall", mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd3,0,0));
    mem_if.mem_ready = 1'b1;
    cyc("lw_read",   mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd3,0,0));
    cyc("lw_wb",     mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,4'd3,1,0));

    // sra / srai / sub / addi with funct7[5] set
    instr = enc(7'b0100000, 5'd7, 5'd6, 3'b101, 5'd5, 7'b0110011);
    cyc("sra_fetch",  V_F);
    cyc("sra_decode", V_D);
    cyc("sra_exec",   mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'd9,0,0));
    cyc("sra_wb",     V_WB);
    instr = enc(7'b0100000, 5'd3, 5'd6, 3'b101, 5'd5, 7'b0010011);
    cyc("srai_fetch", V_F);
    cyc("srai_decode", V_D);
    cyc("srai_exec",  mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'd9,0,0));
    cyc("srai_wb",    V_WB);
    instr = enc(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    cyc("sub_fetch",  V_F);
    cyc("sub_decode", V_D);
    cyc("sub_exec",   mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'd4,0,0));
    cyc("sub_wb",     V_WB);
    instr = enc(7'b0100000, 5'd0, 5'd1, 3'b000, 5'd3, 7'b0010011);
    cyc("addi_fetch", V_F);
    cyc("addi_decode", V_D);
    cyc("addi_exec",  mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'd3,0,0));
    cyc("addi_wb",    V_WB);

    // jal x1 / lui x5
    instr = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd1, 7'b1101111);
    cyc("jal_fetch",  V_F);
    cyc("jal_decode", V_DJ);
    cyc("jal_jal",    mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,3'b011,4'd3,0,0));
    cyc("jal_wb",     V_WB);
    instr = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd5, 7'b0110111);
    cyc("lui_fetch",  V_F);
    cyc("lui_decode", V_D);
    cyc("lui_lui",    mk(0,0,0,0,0,0,2'b00,2'b00,2'b01,3'b100,4'd10,0,0));
    cyc("lui_wb",     V_WB);

    // opcode 0 traps and holds until reset
    instr = 32'd0;
    cyc("trap_fetch",  V_F);
    cyc("trap_decode", V_D);
    for (int i = 0; i < 10; i++)
      cyc("trap_hold", mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd3,0,1));
    reset_pulse("trap_reset");

    // branch funct3 010 is illegal
    instr = enc(7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b1100011);
    cyc("bill_fetch",  V_F);
    cyc("bill_decode", V_D);
    cyc("bill_branch", mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'd4,0,0));
    cyc("bill_trap",   mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd3,0,1));
    reset_pulse("bill_reset");

    // sw x2,8(x1) interrupted by reset while the write is pending
    instr = enc(7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011);
    cyc("sw_fetch",  V_F);
    cyc("sw_decode", V_D);
    mem_if.mem_ready = 1'b0;
    cyc("sw_adr",    mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,4'd3,0,0));
    cyc("sw_write",  mk(0,1,0+1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd3,0,0));
    reset_pulse("sw_reset");
    cyc("sw_refetch", V_FW);
    mem_if.mem_ready = 1'b1;
    cyc("sw_fetch2",  V_F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM of the multicycle RV32I core.
- Directly upstream of the ALU: drives alu_control and the operand selects.
- Consumes the ALU's 5-bit alu_zero_flags to resolve branches.
- Sequences fetch/decode/execute/memory/writeback over one shared memory port with a ready handshake.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- STATE_W, 4, state register width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction register contents (stable outside FETCH)
- alu_zero_flags  in  5  {zero, lt_signed, lt_unsigned, sign, overflow}
- mem_ready  in  1  memory access complete this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- adr_src  out  1  0 = PC, 1 = result bus
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = read data, 10 = live ALU result
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
- imm_src  out  3  I = 000, S = 001, B = 010, J = 011, U = 100
- alu_control  out  4  ALU operation code
- instr_retired  out  1  one-cycle pulse when an instruction completes
- illegal_instr  out  1  sticky trap flag

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low.
- While rst_n = 0: state = FETCH and every output is forced to 0.
- Release of reset: FETCH starts on the first rising edge.
- Reset asserted mid-access: mem_read/mem_write drop immediately; there is no partial writeback.
- Outputs are decoded from state and instr. The only Mealy outputs are pc_write in BRANCH and the mem_ready-qualified strobes.

States (unlisted outputs = 0; ALU op is ADD unless stated):
- FETCH: mem_read = 1, adr_src = 0. Holds while mem_ready = 0. With mem_ready = 1 in the same cycle: ir_write = 1, src_a = 00, src_b = 10, result_src = 10, pc_write = 1, then go to DECODE.
- DECODE: src_a = 01, src_b = 01, imm_src = B; latches the branch target in ALUOut. Next state by opcode:
  - 0000011 / 0100011 -> MEM_ADR
  - 0110011 -> EXECUTE_R
  - 0010011 -> EXECUTE_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> TRAP
- MEM_ADR: src_a = 10, src_b = 01, imm_src = I (loads) or S (stores). Go to MEM_READ for loads, MEM_WRITE for stores.
- MEM_READ: mem_read = 1, adr_src = 1, result_src = 00. Waits for mem_ready, then MEM_WB.
- MEM_WB: result_src = 01, reg_write = 1, then FETCH.
- MEM_WRITE: mem_write = 1, adr_src = 1, result_src = 00. Waits for mem_ready, then FETCH.
- EXECUTE_R: src_a = 10, src_b = 00, then ALU_WB.
- EXECUTE_I: src_a = 10, src_b = 01, imm_src = I, then ALU_WB.
- ALU_WB: result_src = 00, reg_write = 1, then FETCH.
- BRANCH: src_a = 10, src_b = 00, alu_control = SUB, result_src = 00. pc_write = taken, then FETCH. Taken by funct3:
  - 000: zero
  - 001: !zero
  - 100: lt_signed
  - 101: !lt_signed
  - 110: lt_unsigned
  - 111: !lt_unsigned
  - 010 / 011: go to TRAP.
- JALR: src_a = 10, src_b = 01, imm_src = I; ALUOut = rs1 + imm. Then JAL.
- JAL: src_a = 01, src_b = 10, result_src = 00, pc_write = 1, imm_src = J; rd value is OldPC + 4. Then ALU_WB.
  - Entered from DECODE: ALUOut already holds PC + J-imm (imm_src = J in DECODE for opcode 1101111).
- LUI: src_b = 01, imm_src = U, alu_control = LUI, then ALU_WB.
- AUIPC: src_a = 01, src_b = 01, imm_src = U, then ALU_WB.
- TRAP: illegal_instr = 1; stays in TRAP until reset.

ALU decode (EXECUTE_R / EXECUTE_I), by funct3:
- 000: ADD; SUB only for R-type with funct7[5] = 1
- 001: SLL
- 010: SLT
- 011: SLTU
- 100: XOR
- 101: SRL, or SRA when funct7[5] = 1
- 110: OR
- 111: AND

Retirement: instr_retired pulses on every transition into FETCH from a non-FETCH state.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - ALU codes: AND = 0, OR = 1, XOR = 2, ADD = 3, SUB = 4, SLT = 5, SLTU = 6, SLL = 7, SRL = 8, SRA = 9, LUI = 10
  - flag bit indices: ZERO = 4, LTS = 3, LTU = 2, SIGN = 1, OVF = 0
  - opcode constants, imm_src / result_src / src_a / src_b encodings, state enum
- One sub-module, alu_decoder: combinational (opcode, funct3, funct7[5], state) -> alu_control.

Test Plan:
- add x3,x1,x2 with mem_ready tied 1 -> FETCH, DECODE, EXECUTE_R (alu_control = 3), ALU_WB (reg_write = 1); instr_retired on cycle 4.
- beq with flags = 5'b10000 -> pc_write = 1 in BRANCH. bne with the same flags -> pc_write = 0. bltu with flags 5'b00100 -> taken.
- lw with mem_ready held 0 for 3 cycles in MEM_READ -> mem_read stays 1, no state advance; MEM_WB reg_write = 1 after ready.
- sra x5,x6,x7 (funct7 = 0100000, funct3 = 101) -> alu_control = 9. srai -> 9. sub -> 4. addi with funct7[5] = 1 -> 3.
- Opcode 0000000 -> TRAP; illegal_instr = 1 held for 10 cycles; rst_n low clears it immediately.
- rst_n pulsed low mid-MEM_WRITE -> mem_write = 0 asynchronously; FETCH on release.
